control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; the unit SHALL be fixed for RV32I base opcodes.
REQ-002 clk  in  1  single system clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; unit held in reset while 0.
REQ-004 instrCode  in  32  current instruction, stable while PC is unchanged.
REQ-005 busReady  in  1  data bus completion; sampled only in MEM.
REQ-006 PCEn  out  1  PC load enable.
REQ-007 regFileWe  out  1  register file write enable.
REQ-008 aluControl  out  4  ALU op; branch compare in [2:0].
REQ-009 aluSrcMuxSel  out  1  0 = rs2, 1 = immediate.
REQ-010 RFWDSrcMuxSel  out  3  writeback source: 0 ALU, 1 load data, 2 imm, 3 PC+imm, 4 PC+4.
REQ-011 branch, jal, jalr  out  1 each  PC-target selects.
REQ-012 memSize  out  2  00 byte, 01 half, 10 word.
REQ-013 memUnsigned  out  1  zero-extend load.
REQ-014 busWe  out  1  data bus write strobe.

Function
REQ-015 The unit SHALL be a Moore FSM with states FETCH, DECODE, EXECUTE, MEM, WB.
- Every output SHALL be 0 unless listed below.
REQ-016 FETCH: PCEn=1; the next state SHALL be DECODE.
REQ-017 DECODE:
- Legal opcodes (R, I, L, S, B, LUI, AUIPC, JAL, JALR) SHALL go to EXECUTE.
- Any other opcode SHALL return to FETCH with no writes; the PC advances by 4.
REQ-018 EXECUTE SHALL drive decoded controls:
- R: aluControl={funct7[5],funct3}, regFileWe=1, RFWD=0.
- I: aluSrc=1, regFileWe=1, RFWD=0; aluControl={funct7[5]&(funct3==101),funct3}.
- B: aluControl={0,funct3}, branch=1.
- LUI: regFileWe=1, RFWD=2.
- AUIPC: regFileWe=1, RFWD=3.
- JAL: jal=1, regFileWe=1, RFWD=4.
- JALR: jalr=1, aluSrc=1, regFileWe=1, RFWD=4.
- L and S: aluSrc=1, aluControl=ADD (0000).
REQ-019 From EXECUTE, L and S SHALL go to MEM; all other opcodes SHALL go to FETCH.
REQ-020 MEM:
- aluSrc=1 and aluControl=ADD SHALL be held.
- S: busWe=1.
- Exit SHALL occur only on busReady=1: S to FETCH, L to WB.
- While busReady=0, state and all outputs SHALL hold, with no cycle limit.
REQ-021 WB (loads only): regFileWe=1, RFWD=1; the next state SHALL be FETCH.
REQ-022 memSize=funct3[1:0] and memUnsigned=funct3[2] SHALL be driven in every state whenever the opcode is L or S; otherwise both SHALL be 0.
REQ-023 Latency in cycles:
- ALU/branch/jump/upper-immediate: 3.
- Store: 4 + wait cycles.
- Load: 5 + wait cycles.
- Illegal opcode: 2.
REQ-024 busReady outside MEM SHALL be ignored.

Reset
REQ-025 While reset=0, the state SHALL be FETCH and all outputs SHALL be 0, including PCEn.
REQ-026 A reset asserted in any state, including a MEM wait, SHALL abort the instruction immediately with no write strobe after assertion.
REQ-027 After reset release, the first rising edge SHALL execute FETCH with PCEn=1.

Structure
REQ-028 The shared defines package SHALL hold:
- the state enum;
- opcode constants (OP_TYPE_*);
- ALU and branch op constants;
- RFWD select encodings.
REQ-029 A combinational sub-module ctrl_decoder SHALL map instrCode to per-opcode control bundles.
REQ-030 The FSM register and state sequencing SHALL reside in control_unit.

Verification
REQ-031 add x3,x1,x2 (0x002081B3):
- Sequence SHALL be FETCH, DECODE, EXECUTE, with regFileWe=1, aluControl=0000, RFWD=0 in EXECUTE.
- The next cycle SHALL be FETCH with PCEn=1.
REQ-032 lw x5,8(x1) (0x0080A283) with busReady=0 for 2 cycles:
- MEM SHALL last 3 cycles with memSize=10 and busWe=0.
- WB SHALL have regFileWe=1, RFWD=1; total 7 cycles.
REQ-033 sb x2,1(x0) (0x002000A3), busReady=1:
- busWe=1 SHALL occur for exactly one cycle (MEM), with memSize=00.
- regFileWe SHALL never be 1.
REQ-034 beq x0,x0,8 (0x00000463): EXECUTE SHALL have branch=1, aluControl=0000, regFileWe=0, then FETCH.
REQ-035 reset=0 during a stalled store MEM:
- busWe SHALL drop to 0 immediately and the state SHALL be FETCH.
- After release, PCEn=1 SHALL occur on the first cycle.
REQ-036 instrCode 0xFFFFFFFF: sequence SHALL be FETCH, DECODE, FETCH, with no regFileWe or busWe.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit: FSM states,
// opcode constants, ALU/branch op codes, writeback selects and the decoded control bundle.
package control_unit_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4
    } state_t;

    localparam logic [6:0] OP_TYPE_R     = 7'b0110011;
    localparam logic [6:0] OP_TYPE_I     = 7'b0010011;
    localparam logic [6:0] OP_TYPE_L     = 7'b0000011;
    localparam logic [6:0] OP_TYPE_S     = 7'b0100011;
    localparam logic [6:0] OP_TYPE_B     = 7'b1100011;
    localparam logic [6:0] OP_TYPE_LUI   = 7'b0110111;
    localparam logic [6:0] OP_TYPE_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_TYPE_JAL   = 7'b1101111;
    localparam logic [6:0] OP_TYPE_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [2:0] RFWD_ALU    = 3'd0;
    localparam logic [2:0] RFWD_LOAD   = 3'd1;
    localparam logic [2:0] RFWD_IMM    = 3'd2;
    localparam logic [2:0] RFWD_PC_IMM = 3'd3;
    localparam logic [2:0] RFWD_PC_4   = 3'd4;

    typedef struct packed {
        logic       legal;
        logic       is_load;
        logic       is_store;
        logic       reg_we;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic [2:0] rfwd;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [1:0] mem_size;
        logic       mem_unsigned;
    } ctrl_t;

endpackage

// File: rtl/control_unit_decoder.sv
// Combinational opcode decoder: maps the current instruction word to the
// control bundle the FSM drives out during EXECUTE (plus memory access attributes).
module ctrl_decoder
    import control_unit_pkg::*;
(
    input  logic [31:0] instrCode,
    output ctrl_t       ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_instr_bits;

    assign opcode    = instrCode[6:0];
    assign funct3    = instrCode[14:12];
    assign funct7_b5 = instrCode[30];

    // Register indices and most immediate bits never influence control.
    assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    always_comb begin
        // NOTE: the whole bundle is cleared first so no path through the case leaves a field unassigned (no latches).
        ctrl = '0;
        case (opcode)
            OP_TYPE_R: begin
                ctrl.legal    = 1'b1;
                ctrl.reg_we   = 1'b1;
                ctrl.alu_ctrl = {funct7_b5, funct3};
                ctrl.rfwd     = RFWD_ALU;
            end
            OP_TYPE_I: begin
                ctrl.legal    = 1'b1;
                ctrl.reg_we   = 1'b1;
                ctrl.alu_src  = 1'b1;
                // Only SRAI carries funct7[5]; for other immediates bit 30 is immediate data.
                ctrl.alu_ctrl = {funct7_b5 & (funct3 == 3'b101), funct3};
                ctrl.rfwd     = RFWD_ALU;
            end
            OP_TYPE_L: begin
                ctrl.legal    = 1'b1;
                ctrl.is_load  = 1'b1;
                ctrl.alu_src  = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
            end
            OP_TYPE_S: begin
                ctrl.legal    = 1'b1;
                ctrl.is_store = 1'b1;
                ctrl.alu_src  = 1'b1;
                ctrl.alu_ctrl = ALU_ADD;
            end
            OP_TYPE_B: begin
                ctrl.legal    = 1'b1;
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = {1'b0, funct3};
            end
            OP_TYPE_LUI: begin
                ctrl.legal  = 1'b1;
                ctrl.reg_we = 1'b1;
                ctrl.rfwd   = RFWD_IMM;
            end
            OP_TYPE_AUIPC: begin
                ctrl.legal  = 1'b1;
                ctrl.reg_we = 1'b1;
                ctrl.rfwd   = RFWD_PC_IMM;
            end
            OP_TYPE_JAL: begin
                ctrl.legal  = 1'b1;
                ctrl.jal    = 1'b1;
                ctrl.reg_we = 1'b1;
                ctrl.rfwd   = RFWD_PC_4;
            end
            OP_TYPE_JALR: begin
                ctrl.legal   = 1'b1;
                ctrl.jalr    = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.reg_we  = 1'b1;
                ctrl.rfwd    = RFWD_PC_4;
            end
            default: ;
        endcase

        if (ctrl.is_load || ctrl.is_store) begin
            ctrl.mem_size     = funct3[1:0];
            ctrl.mem_unsigned = funct3[2];
        end
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV32I control unit: Moore FSM FETCH/DECODE/EXECUTE/MEM/WB
// sequencing the datapath controls produced by ctrl_decoder.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    input  logic        busReady,
    output logic        PCEn,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic [1:0]  memSize,
    output logic        memUnsigned,
    output logic        busWe
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    ctrl_decoder u_decoder (
        .instrCode (instrCode),
        .ctrl      (ctrl)
    );

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:   state_next = DECODE;
            DECODE:  state_next = ctrl.legal ? EXECUTE : FETCH;
            EXECUTE: state_next = (ctrl.is_load || ctrl.is_store) ? MEM : FETCH;
            MEM: begin
                if (busReady) begin
                    state_next = ctrl.is_load ? WB : FETCH;
                end
            end
            WB:      state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        PCEn          = 1'b0;
        regFileWe     = 1'b0;
        aluControl    = ALU_ADD;
        aluSrcMuxSel  = 1'b0;
        RFWDSrcMuxSel = RFWD_ALU;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        memSize       = 2'b00;
        memUnsigned   = 1'b0;
        busWe         = 1'b0;

        // Outputs are gated by reset directly so strobes drop the moment reset asserts, not at the next edge.
        if (reset) begin
            memSize     = ctrl.mem_size;
            memUnsigned = ctrl.mem_unsigned;
            case (state)
                FETCH: PCEn = 1'b1;
                EXECUTE: begin
                    regFileWe     = ctrl.reg_we;
                    aluControl    = ctrl.alu_ctrl;
                    aluSrcMuxSel  = ctrl.alu_src;
                    RFWDSrcMuxSel = ctrl.rfwd;
                    branch        = ctrl.branch;
                    jal           = ctrl.jal;
                    jalr          = ctrl.jalr;
                end
                MEM: begin
                    aluSrcMuxSel = 1'b1;
                    aluControl   = ALU_ADD;
                    busWe        = ctrl.is_store;
                end
                WB: begin
                    regFileWe     = 1'b1;
                    RFWDSrcMuxSel = RFWD_LOAD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, reset-abort
// sequence and randomized instruction stream checked against a cycle-list model.
module tb_control_unit;

    typedef struct packed {
        logic       pc_en;
        logic       rf_we;
        logic [3:0] alu;
        logic       alu_src;
        logic [2:0] rfwd;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [1:0] mem_size;
        logic       mem_uns;
        logic       bus_we;
    } outs_t;

    typedef struct {
        outs_t o;
        bit    in_mem;
        bit    rdy;
    } exp_cyc_t;

    typedef struct {
        logic [31:0] ins;
        int          waits;
        int          cycles;
        outs_t       exec;
    } vec_t;

    localparam int BOUND = 30;

    logic        clk;
    logic        reset;
    logic [31:0] instrCode;
    logic        busReady;
    logic        PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr, memUnsigned, busWe;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel;
    logic [1:0]  memSize;
    outs_t       dut_o;

    int checks   = 0;
    int failures = 0;
    exp_cyc_t exp_q[$];

    control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .instrCode     (instrCode),
        .busReady      (busReady),
        .PCEn          (PCEn),
        .regFileWe     (regFileWe),
        .aluControl    (aluControl),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .RFWDSrcMuxSel (RFWDSrcMuxSel),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .memSize       (memSize),
        .memUnsigned   (memUnsigned),
        .busWe         (busWe)
    );

    assign dut_o = {PCEn, regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
                    branch, jal, jalr, memSize, memUnsigned, busWe};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic outs_t mk(input logic rf_we, input logic [3:0] alu, input logic src,
                                 input logic [2:0] rfwd, input logic br, input logic j,
                                 input logic jr, input logic [1:0] msize, input logic muns);
        outs_t o;
        o = '0;
        o.rf_we = rf_we; o.alu = alu; o.alu_src = src; o.rfwd = rfwd;
        o.branch = br; o.jal = j; o.jalr = jr; o.mem_size = msize; o.mem_uns = muns;
        return o;
    endfunction

    function automatic void push_exp(input outs_t o, input bit in_mem, input bit rdy);
        exp_cyc_t c;
        c.o = o; c.in_mem = in_mem; c.rdy = rdy;
        exp_q.push_back(c);
    endfunction

    // Expected per-cycle output list for one instruction, from the ISA-level rules.
    function automatic void build_expect(input logic [31:0] ins, input int waits);
        logic [6:0] op;
        logic [2:0] f3;
        bit         is_l, is_s, legal;
        outs_t      base, o;
        op = ins[6:0];
        f3 = ins[14:12];
        is_l = (op == 7'h03);
        is_s = (op == 7'h23);
        exp_q.delete();
        base = '0;
        if (is_l || is_s) begin
            base.mem_size = f3[1:0];
            base.mem_uns  = f3[2];
        end
        o = base; o.pc_en = 1'b1;
        push_exp(o, 0, 0);
        push_exp(base, 0, 0);
        legal = 1;
        o = base;
        case (op)
            7'h33: begin o.rf_we = 1; o.alu = {ins[30], f3}; end
            7'h13: begin o.rf_we = 1; o.alu_src = 1; o.alu = {ins[30] && (f3 == 3'd5), f3}; end
            7'h63: begin o.branch = 1; o.alu = {1'b0, f3}; end
            7'h37: begin o.rf_we = 1; o.rfwd = 3'd2; end
            7'h17: begin o.rf_we = 1; o.rfwd = 3'd3; end
            7'h6F: begin o.jal = 1; o.rf_we = 1; o.rfwd = 3'd4; end
            7'h67: begin o.jalr = 1; o.alu_src = 1; o.rf_we = 1; o.rfwd = 3'd4; end
            7'h03, 7'h23: o.alu_src = 1;
            default: legal = 0;
        endcase
        if (!legal) return;
        push_exp(o, 0, 0);
        if (is_l || is_s) begin
            for (int w = 0; w <= waits; w++) begin
                o = base; o.alu_src = 1; o.bus_we = is_s;
                push_exp(o, 1, w == waits);
            end
        end
        if (is_l) begin
            o = base; o.rf_we = 1; o.rfwd = 3'd1;
            push_exp(o, 0, 0);
        end
    endfunction

    // Entered at the start of a FETCH cycle (after a negedge); returns at the start of the next FETCH.
    task automatic run_instr(input logic [31:0] ins, input int waits, output int lat, output outs_t exec_o);
        int n;
        build_expect(ins, waits);
        n = exp_q.size();
        instrCode = ins;
        #1;
        lat = BOUND;
        exec_o = '0;
        for (int i = 0; i < BOUND; i++) begin
            if (i > 0 && PCEn) begin
                lat = i;
                break;
            end
            if (i < n) begin
                check($sformatf("%08h_cyc%0d", ins, i), 32'(dut_o), 32'(exp_q[i].o));
                busReady = exp_q[i].in_mem ? exp_q[i].rdy : 1'($urandom_range(0, 1));
            end else begin
                busReady = 1'($urandom_range(0, 1));
            end
            if (i == 2) exec_o = dut_o;
            @(negedge clk);
            #1;
        end
        check($sformatf("%08h_latency", ins), 32'(lat), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[$];
        vec_t  v;
        int    lat;
        outs_t ex;

        vecs.push_back('{32'h002081B3, 0, 3, mk(1, 4'b0000, 0, 3'd0, 0, 0, 0, 2'b00, 0)}); // add
        vecs.push_back('{32'h403100B3, 1, 3, mk(1, 4'b1000, 0, 3'd0, 0, 0, 0, 2'b00, 0)}); // sub
        vecs.push_back('{32'h40315093, 0, 3, mk(1, 4'b1101, 1, 3'd0, 0, 0, 0, 2'b00, 0)}); // srai
        vecs.push_back('{32'hFFF00093, 0, 3, mk(1, 4'b0000, 1, 3'd0, 0, 0, 0, 2'b00, 0)}); // addi -1
        vecs.push_back('{32'hFFF04093, 0, 3, mk(1, 4'b0100, 1, 3'd0, 0, 0, 0, 2'b00, 0)}); // xori -1
        vecs.push_back('{32'h0080A283, 2, 7, mk(0, 4'b0000, 1, 3'd0, 0, 0, 0, 2'b10, 0)}); // lw
        vecs.push_back('{32'h002000A3, 0, 4, mk(0, 4'b0000, 1, 3'd0, 0, 0, 0, 2'b00, 0)}); // sb
        vecs.push_back('{32'h00000463, 0, 3, mk(0, 4'b0000, 0, 3'd0, 1, 0, 0, 2'b00, 0)}); // beq
        vecs.push_back('{32'h00001463, 0, 3, mk(0, 4'b0001, 0, 3'd0, 1, 0, 0, 2'b00, 0)}); // bne
        vecs.push_back('{32'h123450B7, 0, 3, mk(1, 4'b0000, 0, 3'd2, 0, 0, 0, 2'b00, 0)}); // lui
        vecs.push_back('{32'h00000097, 0, 3, mk(1, 4'b0000, 0, 3'd3, 0, 0, 0, 2'b00, 0)}); // auipc
        vecs.push_back('{32'h000000EF, 0, 3, mk(1, 4'b0000, 0, 3'd4, 0, 1, 0, 2'b00, 0)}); // jal
        vecs.push_back('{32'h000100E7, 0, 3, mk(1, 4'b0000, 1, 3'd4, 0, 0, 1, 2'b00, 0)}); // jalr
        vecs.push_back('{32'h00014083, 1, 6, mk(0, 4'b0000, 1, 3'd0, 0, 0, 0, 2'b00, 1)}); // lbu
        vecs.push_back('{32'h00201123, 3, 7, mk(0, 4'b0000, 1, 3'd0, 0, 0, 0, 2'b01, 0)}); // sh
        vecs.push_back('{32'hFFFFFFFF, 0, 2, '0});                                          // illegal
        vecs.push_back('{32'h00000000, 0, 2, '0});                                          // illegal

        // Reset holds every output low, even with a load word present and busReady high.
        reset     = 1'b0;
        instrCode = 32'h0080A283;
        busReady  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(dut_o), 32'h0);
        @(posedge clk);
        #2;
        check("reset_outputs_edge", 32'(dut_o), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            v = vecs[k];
            run_instr(v.ins, v.waits, lat, ex);
            check($sformatf("tbl%0d_latency", k), 32'(lat), 32'(v.cycles));
            if (v.cycles > 2)
                check($sformatf("tbl%0d_exec", k), 32'(ex), 32'(v.exec));
        end

        // Reset during a stalled store: strobe drops at once, then FETCH on the first cycle.
        instrCode = 32'h002000A3;
        busReady  = 1'b0;
        #1;
        check("rst_seq_fetch", 32'(PCEn), 32'd1);
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check("rst_seq_mem_buswe", 32'(busWe), 32'd1);
        @(negedge clk);
        #1;
        check("rst_seq_stall_buswe", 32'(busWe), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_seq_abort_buswe", 32'(busWe), 32'd0);
        check("rst_seq_abort_outs", 32'(dut_o), 32'h0);
        busReady = 1'b1;
        @(posedge clk);
        #2;
        check("rst_seq_held_outs", 32'(dut_o), 32'h0);
        reset = 1'b1;
        busReady = 1'b0;
        @(negedge clk);
        run_instr(32'h002081B3, 0, lat, ex);

        // Randomized instruction stream with random bus waits and busReady noise outside MEM.
        for (int r = 0; r < 40; r++) begin
            logic [6:0]  ops[10];
            logic [31:0] ins;
            ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};
            ins = $urandom;
            ops[9] = ins[6:0] ^ 7'h5A;
            ins[6:0] = ops[$urandom_range(0, 9)];
            run_instr(ins, int'($urandom_range(0, 3)), lat, ex);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
